regfile_scoreboard: RTL
=======================

# regfile_scoreboard

Parametrised successor to the single-issue general-purpose register file. It provides:
- configurable data width, register count and number of asynchronous read ports;
- one synchronous write port;
- a per-register pending (scoreboard) bit with a live pending-count.

It sits between decode and writeback of the mini-MIPS core. Multi-cycle producers (load, mult/div) mark their destination register busy at issue. Decode stalls on busy sources until writeback clears them.

## Interface
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, register index width; depth = 2**ADDR_W
- `NUM_RD`, 2, number of read ports
- `clk` in 1, single clock, all state updates on rising edge
- `reset` in 1, asynchronous, active-high; clears all state
- `rd_addr` in NUM_RD*ADDR_W, read indices, port k at bits [k*ADDR_W +: ADDR_W]
- `rd_data` out NUM_RD*DATA_W, read data, same packing
- `rd_busy` out NUM_RD, port k source register pending
- `wr_en` in 1, write strobe
- `wr_addr` in ADDR_W, write index
- `wr_data` in DATA_W, write data
- `sb_set` in 1, mark register pending (issue of multi-cycle op)
- `sb_addr` in ADDR_W, register to mark
- `busy_count` out ADDR_W+1, number of registers currently pending

## Operation
- Register 0 is hardwired:
  - reads always return 0;
  - writes to it are dropped;
  - `sb_set` to it is ignored, so it is never busy.
- Write: when `wr_en` is high and `wr_addr` != 0, the register is loaded at the edge. The same edge clears its pending bit.
- Set: when `sb_set` is high and `sb_addr` != 0, the pending bit is set at the edge.
- Same register written and set in one cycle:
  - the data is written;
  - the pending bit ends up 1, because a new producer is now outstanding.
- `sb_set` on an already-pending register: no change. `busy_count` is unchanged.
- `wr_en` to a non-pending register: data is written. `busy_count` is unchanged.
- `busy_count` update per edge: +1 for a 0→1 pending transition, -1 for a 1→0 transition. A set of one register together with a clear of a different register leaves the count unchanged. The count never exceeds 2**ADDR_W-1.
- Reads are combinational from `rd_addr`, independent per port. Duplicate addresses across ports are legal.
- `rd_busy[k]` equals the pending bit of `rd_addr[k]`; it is 0 for index 0.

## Timing
- Reset assertion, at any time including mid-write, immediately forces:
  - all registers to 0;
  - all pending bits to 0;
  - `busy_count` = 0.
- While reset is high, `rd_data` is 0 and `rd_busy` is 0. Writes and sets are ignored.
- Write-to-read latency: 1 cycle without bypass. Data written at edge N is visible on `rd_data` after edge N.
- Set-to-busy latency: `rd_busy` is high after the edge on which `sb_set` was sampled.
- Clear-to-not-busy: `rd_busy` is low after the write edge. With bypass, it is low in the write cycle itself (see Configuration).
- No handshakes and no stall outputs. The consumer is responsible for stalling on `rd_busy`.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined: write-through forwarding. When `wr_en` is high and `wr_addr` == `rd_addr[k]` != 0:
  - `rd_data[k]` = `wr_data` combinationally in the same cycle;
  - `rd_busy[k]` = 0 in that cycle, unless `sb_set` targets the same register in that cycle.
- Undefined: reads return stored contents only, and `rd_busy` reflects the stored pending bit.
- Storage and `busy_count` behaviour are identical in both builds.

## Structure
- Shared package `regfile_pkg` holds:
  - default constants `REG_DATA_W`=32 and `REG_ADDR_W`=5;
  - `ZERO_REG`=0;
  - typedef `reg_idx_t`, used by decode and hazard logic.
- Sub-module `reg_scoreboard` owns the pending bit-vector and `busy_count`. Its inputs are the set/clear index and strobe pairs; its outputs are the pending vector and the count.
- The top module holds the data array, the read muxes and the bypass logic.

## Test plan
- Reset, then read all indices on both ports -> every `rd_data` = 0, `rd_busy` = 0, `busy_count` = 0.
- Write 0xDEADBEEF to r5, next cycle read r5 on port 0 and port 1 -> both return 0xDEADBEEF.
- Write 0x1234 to r0, then read r0 -> 0. `sb_set` on r0 -> `rd_busy` = 0 and `busy_count` = 0.
- Issue sequence:
  - `sb_set` r3, then `sb_set` r7 -> `busy_count` goes 1, then 2;
  - `sb_set` r3 again -> count stays 2;
  - write r3 together with `sb_set` r9 -> count stays 2, r3 is not busy, r9 is busy.
- Bypass build: write 0xA5A5 to r4 with port 1 reading r4 in the same cycle -> `rd_data[1]` = 0xA5A5 in that cycle. Non-bypass build -> old value in that cycle, 0xA5A5 next cycle.
- Pend r2 and write r6 = 0x55, then assert reset mid-cycle -> all outputs 0 immediately. After release, r6 reads 0 and `busy_count` = 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the register index type used by decode/hazard logic.
package regfile_pkg;

   localparam int unsigned REG_DATA_W = 32;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned ZERO_REG   = 0;

   typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending bits plus a live count of pending registers.
// A set and a clear of the same register in one edge leaves the register pending.
module reg_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned ADDR_W = REG_ADDR_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   set_en,
   input  logic [ADDR_W-1:0]      set_idx,
   input  logic                   clr_en,
   input  logic [ADDR_W-1:0]      clr_idx,
   output logic [(2**ADDR_W)-1:0] pend,
   output logic [ADDR_W:0]        count
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;

   logic [DEPTH-1:0] pend_q, pend_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             set_v, clr_v, inc, dec;

   // Count tracks only real 0->1 and 1->0 transitions of the pending vector.
   always_comb begin
      set_v   = set_en && (set_idx != ADDR_W'(ZERO_REG));
      clr_v   = clr_en && (clr_idx != ADDR_W'(ZERO_REG));
      pend_d  = pend_q;
      if (clr_v) pend_d[clr_idx] = 1'b0;
      if (set_v) pend_d[set_idx] = 1'b1;
      inc     = set_v && !pend_q[set_idx];
      dec     = clr_v && pend_q[clr_idx] && !(set_v && (set_idx == clr_idx));
      count_d = count_q + CNT_W'(inc) - CNT_W'(dec);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q  <= '0;
         count_q <= '0;
      end else begin
         pend_q  <= pend_d;
         count_q <= count_d;
      end
   end

   assign pend  = pend_q;
   assign count = count_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with r0 hardwired to zero and a per-register scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data/clear onto the read ports.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W = REG_DATA_W,
   parameter int unsigned ADDR_W = REG_ADDR_W,
   parameter int unsigned NUM_RD = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     sb_set,
   input  logic [ADDR_W-1:0]        sb_addr,
   output logic [ADDR_W:0]          busy_count
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]  pend;
   logic              wr_v;

   assign wr_v = wr_en && (wr_addr != ADDR_W'(ZERO_REG));

   always_comb begin
      mem_d = mem_q;
      if (wr_v) mem_d[wr_addr] = wr_data;
   end

   // Entry 0 is never written, so it stays zero after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) mem_q <= '{default: '0};
      else       mem_q <= mem_d;
   end

   reg_scoreboard #(
      .ADDR_W (ADDR_W)
   ) u_sb (
      .clk     (clk),
      .reset   (reset),
      .set_en  (sb_set),
      .set_idx (sb_addr),
      .clr_en  (wr_en),
      .clr_idx (wr_addr),
      .pend    (pend),
      .count   (busy_count)
   );

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] idx_c;
      logic [DATA_W-1:0] data_c;
      logic              busy_c;

      assign idx_c = rd_addr[k*ADDR_W +: ADDR_W];

      always_comb begin
         data_c = mem_q[idx_c];
         busy_c = pend[idx_c];
`ifdef REGFILE_BYPASS_EN
         // wr_v excludes r0, so the zero register is never forwarded.
         if (wr_v && (wr_addr == idx_c)) begin
            data_c = wr_data;
            busy_c = sb_set && (sb_addr == idx_c);
         end
`endif
         if (reset) begin
            data_c = '0;
            busy_c = 1'b0;
         end
      end

      assign rd_data[k*DATA_W +: DATA_W] = data_c;
      assign rd_busy[k]                  = busy_c;
   end

endmodule
